rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between two writers. The primary writer is pipeline writeback, which is never stalled. The secondary writer is a long-latency return path, such as multiply/divide or a load miss, and is buffered in a small in-order queue. The block sits between both writers and the regfile's we/wa/wd inputs. It also tells decode which source registers still have a queued, unwritten result.

## Interface
Parameters:
- DEPTH, 4, secondary queue entries (power of 2, ≥2)
- STARVE_LIMIT, 8, consecutive blocked cycles before a_hold fires (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- a_we  in  1  primary write request
- a_wa  in  5  primary destination
- a_wd  in  32  primary data
- b_valid  in  1  secondary write offered
- b_wa  in  5  secondary destination
- b_wd  in  32  secondary data
- b_ready  out  1  secondary accepted this cycle when b_valid&b_ready
- rf_we  out  1  regfile write enable
- rf_wa  out  5  regfile write address
- rf_wd  out  32  regfile write data
- ra1, ra2  in  5  decode source addresses
- pend1, pend2  out  1  ra1/ra2 ≠0 matches a live queued entry
- a_hold  out  1  pipeline must not assert a_we next cycle
- q_count  out  $clog2(DEPTH)+1  occupied entries (live or killed)

## Operation
- Primary wins: if a_we && a_wa≠0, then rf_we=1, rf_wa=a_wa, rf_wd=a_wd, same cycle, combinational.
- Primary write with a_wa=0 is treated as idle and frees the slot.
- Otherwise, if the queue is non-empty, the head is popped. rf_we equals the head's live bit; rf_wa/rf_wd come from the head.
- A killed head still consumes its drain cycle.
- Enqueue: b_valid && b_ready pushes {b_wa, b_wd, live=1} at the tail.
- A secondary offer with b_wa=0 is accepted (b_ready permitting) and discarded, not enqueued.
- b_ready = (q_count < DEPTH) && reset_n. Same-cycle pop does not free space; there is no combinational path from a_we to b_ready.
- WAW squash: a primary write to X≠0 clears the live bit of every queued entry with wa=X. The same-cycle enqueue is younger than the primary write and is not squashed.
- Hazard: pend1/pend2 are combinational over live entries only. An entry being enqueued this cycle is visible from the next cycle.
- Starvation (when compiled in):
  - The age counter increments each cycle the queue is non-empty and the primary wins.
  - It clears on any pop or when the queue is empty.
  - When age reaches STARVE_LIMIT, a_hold is registered high for exactly one cycle and age clears.
  - If a_we is asserted anyway during a_hold, the primary still wins; nothing is dropped.

## Timing
- Primary write latency: 0 cycles.
- Secondary write latency: ≥1 cycle (enqueue at edge N, earliest write at edge N+1).
- Registered state: queue storage, head/tail pointers, q_count, live bits, age, a_hold. rf_*, pend*, b_ready are combinational.
- Reset (any time, asynchronous):
  - q_count=0, all live=0, pointers=0, age=0, a_hold=0, b_ready=0.
  - rf_we=0 unless a_we asserts.
  - Queued writes in flight at reset are lost.
- Full plus simultaneous pop: b_ready stays 0 that cycle and returns to 1 the cycle after.
- Empty plus b_valid with no primary: the entry is enqueued; rf_we=0 this cycle and writes next cycle.
- Pointers wrap modulo DEPTH.

## Configuration
- RFARB_STARVE_EN defined: the age counter and a_hold logic are present as described.
- RFARB_STARVE_EN undefined: a_hold is tied 0, there is no age counter, and STARVE_LIMIT is unused. The secondary may then starve indefinitely under continuous primary writes.

## Structure
- Package rf_arb_pkg holds:
  - constants RF_AW=5 and RF_DW=32;
  - typedef rf_wr_t {wa, wd};
  - typedef rf_q_entry_t {live, wa, wd}.
- Sub-module rf_arb_queue is the circular buffer. It provides push/pop, a per-entry kill-by-address port, and two address-match outputs.
- rf_write_arbiter holds arbitration, the output mux, and the starvation counter.

## Test plan
- Primary only: a_we=1, a_wa=5, a_wd=0xDEADBEEF with empty queue → rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF same cycle; b_ready=1.
- Contention: push b_wa=7/0x11 while a_we=1 for 3 cycles → entry held, pend(ra1=7)=1. On the first a_we=0 cycle → rf_wa=7, rf_wd=0x11; pend1=0 the next cycle.
- Full: push 4 entries with a_we=1 continuously → q_count=4, b_ready=0. After one a_we=0 cycle pops one → b_ready=1 next cycle.
- WAW squash: queue holds wa=9/0xAA; primary writes wa=9/0xBB → when popped, rf_we=0. Regfile holds 0xBB; pend for 9 clears immediately.
- Starvation (RFARB_STARVE_EN): one queued entry with a_we=1 held for 8 cycles → a_hold=1 for exactly one cycle. The bench drops a_we → entry written that cycle.
- Reset mid-operation: 3 entries queued, reset_n pulsed low between edges → q_count=0, pend*=0, a_hold=0, b_ready=0 immediately. b_ready=1 after release.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write arbiter.
package rf_arb_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef struct packed {
        logic [RF_AW-1:0] wa;
        logic [RF_DW-1:0] wd;
    } rf_wr_t;

    typedef struct packed {
        logic             live;
        logic [RF_AW-1:0] wa;
        logic [RF_DW-1:0] wd;
    } rf_q_entry_t;

endpackage

// File: rtl/rf_arb_queue.sv
// In-order circular buffer for secondary writes. Entries carry a live bit
// that can be cleared by address (WAW squash) while the slot stays occupied
// until it drains. Match outputs look at live entries only.
module rf_arb_queue
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [RF_AW-1:0]            push_wa,
    input  logic [RF_DW-1:0]            push_wd,
    input  logic                        pop,
    input  logic                        kill,
    input  logic [RF_AW-1:0]            kill_wa,
    input  logic [RF_AW-1:0]            ra1,
    input  logic [RF_AW-1:0]            ra2,
    output logic                        head_live,
    output logic [RF_AW-1:0]            head_wa,
    output logic [RF_DW-1:0]            head_wd,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        match1,
    output logic                        match2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rf_q_entry_t   mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          m1;
    logic          m2;

    // Storage, pointers and occupancy; a push lands after any kill so the
    // newest entry is never squashed by the same-cycle primary write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].wa == kill_wa) mem[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem[head_ptr].live <= 1'b0;
                head_ptr           <= head_ptr + PW'(1);
            end
            if (push) begin
                mem[tail_ptr] <= '{live: 1'b1, wa: push_wa, wd: push_wd};
                tail_ptr      <= tail_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Address match against live entries; free slots always have live=0.
    always_comb begin
        m1 = 1'b0;
        m2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live && mem[i].wa == ra1) m1 = 1'b1;
            if (mem[i].live && mem[i].wa == ra2) m2 = 1'b1;
        end
    end

    assign match1    = m1 && (ra1 != '0);
    assign match2    = m2 && (ra2 != '0);
    assign head_live = mem[head_ptr].live;
    assign head_wa   = mem[head_ptr].wa;
    assign head_wd   = mem[head_ptr].wd;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, the
// long-latency return path is queued and drains in idle cycles.
// Optional starvation guard: define RFARB_STARVE_EN to build the age counter
// and a_hold; otherwise a_hold is tied low.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   a_we,
    input  logic [4:0]             a_wa,
    input  logic [31:0]            a_wd,
    input  logic                   b_valid,
    input  logic [4:0]             b_wa,
    input  logic [31:0]            b_wd,
    output logic                   b_ready,
    output logic                   rf_we,
    output logic [4:0]             rf_wa,
    output logic [31:0]            rf_wd,
    input  logic [4:0]             ra1,
    input  logic [4:0]             ra2,
    output logic                   pend1,
    output logic                   pend2,
    output logic                   a_hold,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("rf_write_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    logic             a_win;
    logic             q_empty;
    logic             pop;
    logic             push;
    logic             head_live;
    logic [RF_AW-1:0] head_wa;
    logic [RF_DW-1:0] head_wd;

    // A primary write to r0 is no write at all and leaves the port free.
    assign a_win   = a_we && (a_wa != '0);
    assign q_empty = (q_count == '0);
    assign pop     = !a_win && !q_empty;
    // Space is judged on registered occupancy only, so a_we never reaches b_ready.
    assign b_ready = (q_count < CW'(DEPTH)) && reset_n;
    assign push    = b_valid && b_ready && (b_wa != '0);

    rf_arb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_wa   (b_wa),
        .push_wd   (b_wd),
        .pop       (pop),
        .kill      (a_win),
        .kill_wa   (a_wa),
        .ra1       (ra1),
        .ra2       (ra2),
        .head_live (head_live),
        .head_wa   (head_wa),
        .head_wd   (head_wd),
        .count     (q_count),
        .match1    (pend1),
        .match2    (pend2)
    );

    // Write-port mux: primary first, else the queue head (a killed head drains silently).
    always_comb begin
        rf_we = 1'b0;
        rf_wa = head_wa;
        rf_wd = head_wd;
        if (a_win) begin
            rf_we = 1'b1;
            rf_wa = a_wa;
            rf_wd = a_wd;
        end else if (pop) begin
            rf_we = head_live;
        end
    end

`ifdef RFARB_STARVE_EN
    localparam int AGW = $clog2(STARVE_LIMIT) + 1;

    logic [AGW-1:0] age;
    logic           hold_r;

    // Count cycles the queue is blocked by the primary; fire a one-cycle hold at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            age    <= '0;
            hold_r <= 1'b0;
        end else if (!q_empty && a_win) begin
            if (age == AGW'(STARVE_LIMIT - 1)) begin
                age    <= '0;
                hold_r <= 1'b1;
            end else begin
                age    <= age + AGW'(1);
                hold_r <= 1'b0;
            end
        end else begin
            age    <= '0;
            hold_r <= 1'b0;
        end
    end

    assign a_hold = hold_r;
`else
    assign a_hold = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: the driver predicts each cycle's
// combinational outputs from a queue-based reference model and pushes them;
// a negedge monitor pops and compares against the DUT.
module tb_rf_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef RFARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_we = 1'b0;
    logic [4:0]  a_wa = '0;
    logic [31:0] a_wd = '0;
    logic        b_valid = 1'b0;
    logic [4:0]  b_wa = '0;
    logic [31:0] b_wd = '0;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic        pend1;
    logic        pend2;
    logic        a_hold;
    logic [2:0]  q_count;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_wa(b_wa), .b_wd(b_wd), .b_ready(b_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .ra1(ra1), .ra2(ra2), .pend1(pend1), .pend2(pend2),
        .a_hold(a_hold), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        live;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ment_t;

    typedef struct {
        logic        we;
        logic        has_src;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        br;
        logic        p1;
        logic        p2;
        logic        hold;
        int          cnt;
    } exp_t;

    ment_t mq[$];
    exp_t  exp_q[$];
    exp_t  e_mon;
    int    total = 0;
    int    bad = 0;
    int    age_m = 0;
    logic  hold_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic pend_of(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].wa == r) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of stimulus: drive, predict, then advance the model.
    task automatic cycle(input logic awe, input logic [4:0] awa, input logic [31:0] awd,
                         input logic bv, input logic [4:0] bwa, input logic [31:0] bwd,
                         input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        bit   win;
        @(posedge clk);
        #1;
        a_we = awe; a_wa = awa; a_wd = awd;
        b_valid = bv; b_wa = bwa; b_wd = bwd;
        ra1 = r1; ra2 = r2;

        win    = awe && (awa != 5'd0);
        e.br   = (mq.size() < DEPTH);
        e.p1   = pend_of(r1);
        e.p2   = pend_of(r2);
        e.cnt  = mq.size();
        e.hold = hold_m;
        if (win) begin
            e.we = 1'b1; e.has_src = 1'b1; e.wa = awa; e.wd = awd;
        end else if (mq.size() > 0) begin
            e.we = mq[0].live; e.has_src = 1'b1; e.wa = mq[0].wa; e.wd = mq[0].wd;
        end else begin
            e.we = 1'b0; e.has_src = 1'b0; e.wa = '0; e.wd = '0;
        end
        exp_q.push_back(e);

        if (STARVE_ON && win && mq.size() > 0) begin
            age_m++;
            if (age_m == LIMIT) begin
                hold_m = 1'b1;
                age_m  = 0;
            end else begin
                hold_m = 1'b0;
            end
        end else begin
            age_m  = 0;
            hold_m = 1'b0;
        end

        if (win) begin
            foreach (mq[i]) if (mq[i].wa == awa) mq[i].live = 1'b0;
        end else if (mq.size() > 0) begin
            void'(mq.pop_front());
        end
        if (bv && e.br && bwa != 5'd0) mq.push_back('{1'b1, bwa, bwd});
    endtask

    // Idle cycle, then an asynchronous reset pulse between clock edges.
    task automatic pulse_reset(input logic [4:0] r1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_pend1", 32'(pend1), 32'd0);
        chk("rst_pend2", 32'(pend2), 32'd0);
        chk("rst_a_hold", 32'(a_hold), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        #1 reset_n = 1'b1;
        #1;
        chk("post_rst_b_ready", 32'(b_ready), 32'd1);
        mq.delete();
        age_m  = 0;
        hold_m = 1'b0;
    endtask

    // Monitor: compare every predicted cycle mid-period.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            chk("rf_we", 32'(rf_we), 32'(e_mon.we));
            if (e_mon.has_src) begin
                chk("rf_wa", 32'(rf_wa), 32'(e_mon.wa));
                chk("rf_wd", rf_wd, e_mon.wd);
            end
            chk("b_ready", 32'(b_ready), 32'(e_mon.br));
            chk("pend1", 32'(pend1), 32'(e_mon.p1));
            chk("pend2", 32'(pend2), 32'(e_mon.p2));
            chk("q_count", 32'(q_count), 32'(e_mon.cnt));
            chk("a_hold", 32'(a_hold), 32'(e_mon.hold));
        end
    end

    initial begin
        #3;
        chk("init_b_ready", 32'(b_ready), 32'd0);
        chk("init_q_count", 32'(q_count), 32'd0);
        chk("init_a_hold", 32'(a_hold), 32'd0);
        chk("init_rf_we", 32'(rf_we), 32'd0);
        #9 reset_n = 1'b1;

        // primary only
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        // contention: secondary held behind three primary writes, then drains
        cycle(1'b1, 5'd3, 32'h1, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
        cycle(1'b1, 5'd4, 32'h2, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        cycle(1'b1, 5'd6, 32'h3, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);

        // fill to DEPTH, offer while full, pop once, then space returns
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'h100 + 32'(i), 5'd11, 5'd13);
        cycle(1'b1, 5'd1, 32'h9, 1'b1, 5'd14, 32'h200, 5'd14, 5'd10);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'h300, 5'd10, 5'd0);
        cycle(1'b1, 5'd2, 32'h5, 1'b0, 5'd0, 32'd0, 5'd15, 5'd11);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd15);

        // WAW squash
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd0);
        cycle(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);

        // starvation: one entry blocked for LIMIT cycles, pipeline yields on a_hold
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd0);
        for (int i = 0; i < LIMIT; i++)
            cycle(1'b1, 5'd2, 32'h40 + 32'(i), 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);

        // reset with three entries in flight
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'd1, 32'h7, 1'b1, 5'(20 + i), 32'h500 + 32'(i), 5'd20, 5'd22);
        pulse_reset(5'd20);

        // randomized traffic over a small address range to force collisions
        for (int n = 0; n < 600; n++) begin
            logic awe;
            awe = ($urandom_range(0, 99) < 60);
            if (hold_m && $urandom_range(0, 1) == 0) awe = 1'b0;
            cycle(awe, 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (n == 300) pulse_reset(5'($urandom_range(1, 7)));
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
